stereo_param_link: RTL and testbench
====================================

// Module: stereo_param_link
// PURPOSE
//  Parametrised master/slave serial link that carries camera control parameters
//  (gain, integration time, zoom, ...) from the master camera FPGA to the slave over two wires.
//  Generalises the fixed 72-bit stereo control link with:
//   - configurable payload and sync widths, and a divided bit clock;
//   - CRC-8 protection, stop-bit and link-timeout checking;
//   - an error counter, and full single-clock-domain operation (the slave oversamples SCL/SDA).
// PARAMETERS
//  PAYLOAD_W  65      payload bits per frame ({zoom[31:0], int_time[31:0], gain}); must be >=1
//  SYNC_W     7       sync-word width
//  SYNC_WORD  7'd42   sync-word value
//  HALF_DIV   4       CLK cycles per SCL half-period (>=2); bit period = 2*HALF_DIV
//  GAP_BITS   50      idle bit periods (SDA=1) between master frames
//  TIMEOUT    1024    CLK cycles with no SCL rising edge that abort RX / drop LINK_UP
// PORTS
//  CLK          in   1          system clock
//  RESET        in   1          asynchronous, active-high reset
//  MODE_SLAVE   in   1          0 = master (transmit), 1 = slave (receive)
//  TX_PAYLOAD   in   PAYLOAD_W  master: parameters to send
//  TX_BUSY      out  1          master: frame in flight
//  TX_DONE      out  1          master: 1-cycle pulse after stop bit driven
//  SCL_OUT      out  1          master bit clock
//  SDA_OUT      out  1          master serial data
//  LINK_OE      out  1          pad output enable (=~MODE_SLAVE, registered)
//  SCL_IN       in   1          slave: bit clock from pad (asynchronous)
//  SDA_IN       in   1          slave: serial data from pad (asynchronous)
//  RX_PAYLOAD   out  PAYLOAD_W  slave: last good payload (held)
//  RX_VALID     out  1          slave: 1-cycle pulse when RX_PAYLOAD updated
//  RX_ERR       out  1          slave: 1-cycle pulse on rejected frame
//  ERR_CNT      out  16         slave: rejected-frame count, saturates at 16'hFFFF
//  LINK_UP      out  1          slave: 1 after a good frame, 0 after a timeout or a bad frame
// BEHAVIOUR
//  Reset values:
//   - SCL_OUT=1, SDA_OUT=1, LINK_OE=0, TX_BUSY=0, TX_DONE=0
//   - RX_PAYLOAD=0, RX_VALID=0, RX_ERR=0, ERR_CNT=0, LINK_UP=0
//   - both FSMs return to their idle state.
//  Frame format (F = SYNC_W+PAYLOAD_W+10 bits, all fields LSB first):
//   - start 0, SYNC_WORD, payload, CRC[7:0], stop 1.
//  CRC-8: poly 0x07, init 0x00, bit-serial over sync+payload:
//   - fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 8'h07 : 0).
//  Master:
//   - SCL_OUT toggles every HALF_DIV cycles and runs continuously while MODE_SLAVE=0.
//   - SDA_OUT changes only on an SCL_OUT falling edge.
//   - FSM GAP->TX->GAP. GAP holds SDA=1 for GAP_BITS bit periods, then enters TX.
//   - TX_PAYLOAD is latched on the falling edge that launches the start bit; later input changes
//     affect only the next frame. TX_BUSY=1 in TX.
//   - After the stop bit has been driven for one full bit period: TX_DONE pulses, FSM returns to GAP.
//  Slave:
//   - SCL_IN and SDA_IN each pass a 2-FF synchroniser; an SCL rising edge is detected on the
//     synchronised value, and SDA is sampled on that edge.
//   - FSM HUNT->RX->CHECK->HUNT.
//   - HUNT: a sampled SDA=0 enters RX (bit count=1, CRC init).
//   - RX: shift F-1 more bits; after the stop-bit sample, enter CHECK.
//   - CHECK (1 cycle): good = sync match & CRC match & stop==1.
//     - Good: RX_PAYLOAD<=payload, RX_VALID=1, LINK_UP=1.
//     - Bad: RX_ERR=1, ERR_CNT+1 (saturating), LINK_UP=0.
//   - Latency: RX_VALID/RX_ERR assert 2 CLK cycles after the detected stop-bit edge.
//   - Timeout: TIMEOUT cycles without an SCL edge, in any state, give LINK_UP=0. In RX it also
//     gives RX_ERR pulse, ERR_CNT+1, and return to HUNT.
//  MODE_SLAVE change mid-frame:
//   - the new role starts from its idle state the next cycle;
//   - a partial frame is discarded with no RX_ERR; RX_PAYLOAD and ERR_CNT are kept.
//  Master outputs are held at their reset values while MODE_SLAVE=1. Slave logic is frozen while
//  MODE_SLAVE=0, except that LINK_UP is forced to 0.
// TESTING
//  Test 1: master->slave loopback; TX_PAYLOAD=65'h1_DEADBEEF_12345678
//   -> RX_VALID once per frame, RX_PAYLOAD equal to the sent value, ERR_CNT=0, LINK_UP=1.
//  Test 2: flip payload bit 10 in the channel
//   -> RX_ERR pulse, ERR_CNT=1, LINK_UP=0, RX_PAYLOAD keeps the previous value;
//      the next clean frame gives RX_VALID and LINK_UP=1.
//  Test 3: sync word 43 injected
//   -> frame rejected (ERR_CNT+1); stop bit forced 0 -> rejected.
//  Test 4: SCL held high for 1100 cycles mid-frame
//   -> RX_ERR, return to HUNT, LINK_UP=0; the next frame is received correctly.
//  Test 5: TX_PAYLOAD changed during TX
//   -> the current frame carries the old value, the next frame the new one;
//      TX_BUSY high for exactly F*8 cycles (default HALF_DIV=4).
//  Test 6: RESET asserted mid-frame, then MODE_SLAVE toggled mid-frame
//   -> all outputs at reset values immediately; after a mode toggle no spurious RX_VALID/RX_ERR.

Source files
------------

// File: rtl/stereo_param_link_if.sv
// Link-side signals of stereo_param_link: the master modport is the transmit side and the
// slave modport is the receive side. One instance can feed both ports of the block.
interface stereo_param_link_if #(
  parameter int PAYLOAD_W = 65
);
  logic [PAYLOAD_W-1:0] TX_PAYLOAD;
  logic                 TX_BUSY;
  logic                 TX_DONE;
  logic                 SCL_OUT;
  logic                 SDA_OUT;
  logic                 LINK_OE;
  logic                 SCL_IN;
  logic                 SDA_IN;
  logic [PAYLOAD_W-1:0] RX_PAYLOAD;
  logic                 RX_VALID;
  logic                 RX_ERR;
  logic [15:0]          ERR_CNT;
  logic                 LINK_UP;

  modport master (input TX_PAYLOAD, output TX_BUSY, TX_DONE, SCL_OUT, SDA_OUT, LINK_OE);
  modport slave  (input SCL_IN, SDA_IN, output RX_PAYLOAD, RX_VALID, RX_ERR, ERR_CNT, LINK_UP);
endinterface

// File: rtl/stereo_param_link.sv
// Two-wire camera parameter link: master serialises start/sync/payload/CRC-8/stop frames on a
// divided SCL; slave oversamples SCL/SDA, checks sync, CRC and stop, and tracks link health.
module stereo_param_link #(
  parameter int                PAYLOAD_W = 65,
  parameter int                SYNC_W    = 7,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 7'd42,
  parameter int                HALF_DIV  = 4,
  parameter int                GAP_BITS  = 50,
  parameter int                TIMEOUT   = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MODE_SLAVE,
  stereo_param_link_if.master mst,
  stereo_param_link_if.slave  slv
);
  localparam int D_W   = SYNC_W + PAYLOAD_W;
  localparam int F_W   = D_W + 10;
  localparam int IDX_W = $clog2(F_W + 1);
  localparam int HC_W  = $clog2(HALF_DIV);
  localparam int GC_W  = $clog2(GAP_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] I_DLAST = IDX_W'(D_W);
  localparam logic [IDX_W-1:0] I_CLAST = IDX_W'(D_W + 8);
  localparam logic [IDX_W-1:0] I_STOP  = IDX_W'(F_W - 1);
  localparam logic [HC_W-1:0]  H_LAST  = HC_W'(HALF_DIV - 1);
  localparam logic [GC_W-1:0]  G_LAST  = GC_W'(GAP_BITS - 1);
  localparam logic [TO_W-1:0]  T_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  T_MAX   = TO_W'(TIMEOUT);

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    crc8_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  typedef enum logic {M_GAP, M_TX} m_state_t;
  m_state_t         m_state_q, m_state_d;
  logic [HC_W-1:0]  half_q;
  logic             scl_q, sda_q, sda_d, done_q, done_d, oe_q;
  logic [GC_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [D_W-1:0]   dsr_q, dsr_d;
  logic [7:0]       crc_q, crc_d;
  logic             fall;

  // Everything on the master side advances only on the SCL falling edge about to happen.
  assign fall = (half_q == H_LAST) && scl_q;

  always_comb begin
    m_state_d = m_state_q;
    sda_d     = sda_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    dsr_d     = dsr_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    if (fall) begin
      case (m_state_q)
        M_GAP: begin
          if (gap_q == G_LAST) begin
            m_state_d = M_TX;
            sda_d     = 1'b0;
            idx_d     = IDX_W'(1);
            dsr_d     = {mst.TX_PAYLOAD, SYNC_WORD};
            crc_d     = 8'h00;
            gap_d     = '0;
          end else begin
            gap_d = gap_q + GC_W'(1);
          end
        end
        M_TX: begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q <= I_DLAST) begin
            sda_d = dsr_q[0];
            dsr_d = dsr_q >> 1;
            crc_d = crc8_step(crc_q, dsr_q[0]);
          end else if (idx_q <= I_CLAST) begin
            sda_d = crc_q[0];
            crc_d = crc_q >> 1;
          end else if (idx_q == I_STOP) begin
            sda_d = 1'b1;
          end else begin
            m_state_d = M_GAP;
            done_d    = 1'b1;
            idx_d     = '0;
          end
        end
        default: m_state_d = M_GAP;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_state_q <= M_GAP; half_q <= '0; scl_q <= 1'b1; sda_q <= 1'b1; done_q <= 1'b0;
      gap_q <= '0; idx_q <= '0; dsr_q <= '0; crc_q <= '0; oe_q <= 1'b0;
    end else if (MODE_SLAVE) begin
      m_state_q <= M_GAP; half_q <= '0; scl_q <= 1'b1; sda_q <= 1'b1; done_q <= 1'b0;
      gap_q <= '0; idx_q <= '0; dsr_q <= '0; crc_q <= '0; oe_q <= 1'b0;
    end else begin
      m_state_q <= m_state_d;
      half_q    <= (half_q == H_LAST) ? '0 : half_q + HC_W'(1);
      scl_q     <= (half_q == H_LAST) ? ~scl_q : scl_q;
      sda_q     <= sda_d;
      done_q    <= done_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      dsr_q     <= dsr_d;
      crc_q     <= crc_d;
      oe_q      <= 1'b1;
    end
  end

  assign mst.TX_BUSY = (m_state_q == M_TX);
  assign mst.TX_DONE = done_q;
  assign mst.SCL_OUT = scl_q;
  assign mst.SDA_OUT = sda_q;
  assign mst.LINK_OE = oe_q;

  // Synchronisers idle high so a reset never fakes an SCL edge or a start bit.
  logic scl_m, scl_s, scl_p, sda_m, sda_s, rise;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scl_m <= 1'b1; scl_s <= 1'b1; scl_p <= 1'b1; sda_m <= 1'b1; sda_s <= 1'b1;
    end else begin
      scl_m <= slv.SCL_IN; scl_s <= scl_m; scl_p <= scl_s;
      sda_m <= slv.SDA_IN; sda_s <= sda_m;
    end
  end
  assign rise = scl_s & ~scl_p;

  typedef enum logic [1:0] {S_HUNT, S_RX, S_CHECK} s_state_t;
  s_state_t             s_state_q, s_state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [F_W-2:0]       sr_q, sr_d;
  logic [7:0]           rcrc_q, rcrc_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic                 vld_q, vld_d, err_q, err_d, up_q, up_d, tmo, bump, good;
  logic [15:0]          ecnt_q, ecnt_d;

  // sr_q holds every bit after the start bit, first-received at bit 0.
  assign tmo  = !rise && (to_q == T_LAST);
  assign good = (sr_q[SYNC_W-1:0] == SYNC_WORD) && (sr_q[D_W+7:D_W] == rcrc_q) && sr_q[F_W-2];

  always_comb begin
    s_state_d = s_state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    rcrc_d    = rcrc_q;
    pay_d     = pay_q;
    up_d      = up_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    bump      = 1'b0;
    to_d      = rise ? '0 : ((to_q == T_MAX) ? to_q : to_q + TO_W'(1));
    if (tmo) up_d = 1'b0;
    case (s_state_q)
      S_HUNT: begin
        if (rise && !sda_s) begin
          s_state_d = S_RX;
          cnt_d     = IDX_W'(1);
          rcrc_d    = 8'h00;
        end
      end
      S_RX: begin
        if (rise) begin
          sr_d  = {sda_s, sr_q[F_W-2:1]};
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q <= I_DLAST) rcrc_d = crc8_step(rcrc_q, sda_s);
          if (cnt_q == I_STOP) s_state_d = S_CHECK;
        end else if (tmo) begin
          s_state_d = S_HUNT;
          err_d     = 1'b1;
          bump      = 1'b1;
        end
      end
      S_CHECK: begin
        s_state_d = S_HUNT;
        if (good) begin
          pay_d = sr_q[D_W-1:SYNC_W];
          vld_d = 1'b1;
          up_d  = 1'b1;
        end else begin
          err_d = 1'b1;
          bump  = 1'b1;
          up_d  = 1'b0;
        end
      end
      default: s_state_d = S_HUNT;
    endcase
    ecnt_d = (bump && ecnt_q != 16'hFFFF) ? ecnt_q + 16'd1 : ecnt_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_state_q <= S_HUNT; cnt_q <= '0; sr_q <= '0; rcrc_q <= '0; to_q <= '0;
      pay_q <= '0; vld_q <= 1'b0; err_q <= 1'b0; up_q <= 1'b0; ecnt_q <= '0;
    end else if (!MODE_SLAVE) begin
      s_state_q <= S_HUNT; to_q <= '0; vld_q <= 1'b0; err_q <= 1'b0; up_q <= 1'b0;
    end else begin
      s_state_q <= s_state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rcrc_q    <= rcrc_d;
      to_q      <= to_d;
      pay_q     <= pay_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      up_q      <= up_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign slv.RX_PAYLOAD = pay_q;
  assign slv.RX_VALID   = vld_q;
  assign slv.RX_ERR     = err_q;
  assign slv.ERR_CNT    = ecnt_q;
  assign slv.LINK_UP    = up_q;
endmodule

// File: tb/tb_stereo_param_link.sv
// Master instance loops back into a slave instance through a channel that can flip one frame
// bit or hold SCL high; directed steps check framing, rejection, timeout, reset and mode changes.
module tb_stereo_param_link;
  localparam logic [64:0] P1 = 65'h1_DEADBEEF_12345678;
  localparam logic [64:0] P2 = 65'h0_CAFEF00D_0BADC0DE;

  logic clk, rst, m_mode, s_mode, hold_scl;
  int   ncmp = 0, nerr = 0, vcnt = 0, ecnt = 0, vseen = 0, eseen = 0;
  int   idx = -1, flip_idx = -1;
  logic prev_scl = 1'b1;
  logic [81:0] cap;

  stereo_param_link_if #(.PAYLOAD_W(65)) m_if ();
  stereo_param_link_if #(.PAYLOAD_W(65)) s_if ();

  stereo_param_link u_m (.CLK(clk), .RESET(rst), .MODE_SLAVE(m_mode), .mst(m_if), .slv(m_if));
  stereo_param_link u_s (.CLK(clk), .RESET(rst), .MODE_SLAVE(s_mode), .mst(s_if), .slv(s_if));

  assign m_if.SCL_IN = 1'b1;
  assign m_if.SDA_IN = 1'b1;
  assign s_if.SCL_IN = hold_scl | m_if.SCL_OUT;
  assign s_if.SDA_IN = m_if.SDA_OUT ^ ((flip_idx >= 0) && (idx == flip_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tracks which frame bit the master is driving, captures the wire, and counts slave pulses.
  always @(negedge clk) begin
    if (rst) begin
      idx = -1;
      prev_scl = 1'b1;
    end else begin
      if (prev_scl && !m_if.SCL_OUT) idx = m_if.TX_BUSY ? idx + 1 : -1;
      if (!prev_scl && m_if.SCL_OUT && idx >= 0 && idx < 82) cap[idx] = m_if.SDA_OUT;
      prev_scl = m_if.SCL_OUT;
    end
    if (s_if.RX_VALID) vcnt++;
    if (s_if.RX_ERR) ecnt++;
  end

  function automatic logic [81:0] mk_frame(input logic [64:0] p);
    logic [71:0] d;
    logic [7:0]  c;
    logic        fb;
    d = {p, 7'd42};
    c = 8'h00;
    for (int i = 0; i < 72; i++) begin
      fb = c[7] ^ d[i];
      c  = (c << 1) ^ (fb ? 8'h07 : 8'h00);
    end
    return {1'b1, c, p, 7'd42, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idx(input int target, input string tag);
    int n = 0;
    while (idx != target && n < 2600) begin @(negedge clk); n++; end
    chk(tag, (idx == target), 1);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (m_if.TX_BUSY !== lvl && n < 2600) begin @(negedge clk); n++; end
    chk(tag, m_if.TX_BUSY, lvl);
  endtask

  task automatic wait_evt(output logic gv, output logic ge);
    int n = 0;
    while (vcnt == vseen && ecnt == eseen && n < 2600) begin @(negedge clk); n++; end
    gv = (vcnt != vseen);
    ge = (ecnt != eseen);
    vseen = vcnt;
    eseen = ecnt;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mst"}, {m_if.SCL_OUT, m_if.SDA_OUT, m_if.LINK_OE, m_if.TX_BUSY, m_if.TX_DONE}, 5'b11000);
    chk({tag, "_pay"}, s_if.RX_PAYLOAD, 65'h0);
    chk({tag, "_slv"}, {s_if.RX_VALID, s_if.RX_ERR, s_if.LINK_UP, s_if.ERR_CNT}, 19'h0);
  endtask

  initial begin
    logic gv, ge;
    int   busy_cyc;
    rst = 1'b1; m_mode = 1'b0; s_mode = 1'b1; hold_scl = 1'b0;
    m_if.TX_PAYLOAD = P1;
    s_if.TX_PAYLOAD = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Test 1: clean loopback
    wait_evt(gv, ge);
    chk("t1_evt", {gv, ge}, 2'b10);
    chk("t1_pay", s_if.RX_PAYLOAD, P1);
    chk("t1_up_cnt", {s_if.LINK_UP, s_if.ERR_CNT}, {1'b1, 16'd0});
    chk("t1_frame", cap, mk_frame(P1));
    chk("t1_oe", {m_if.LINK_OE, s_if.LINK_OE}, 2'b10);
    chk("t1_slv_mst", {s_if.SCL_OUT, s_if.SDA_OUT, s_if.TX_BUSY, s_if.TX_DONE}, 4'b1100);
    wait_evt(gv, ge);
    chk("t1_evt2", {gv, ge}, 2'b10);
    chk("t1_counts", {vcnt[7:0], ecnt[7:0]}, {8'd2, 8'd0});

    // Test 2: payload bit 10 flipped
    wait_busy(1'b0, "t2_idle");
    flip_idx = 18;
    wait_evt(gv, ge);
    flip_idx = -1;
    chk("t2_evt", {gv, ge}, 2'b01);
    chk("t2_cnt_up", {s_if.ERR_CNT, s_if.LINK_UP}, {16'd1, 1'b0});
    chk("t2_pay_kept", s_if.RX_PAYLOAD, P1);
    wait_evt(gv, ge);
    chk("t2_recover", {gv, ge, s_if.LINK_UP}, 3'b101);

    // Test 3: sync word 43, then stop bit forced low
    wait_busy(1'b0, "t3_idle");
    flip_idx = 1;
    wait_evt(gv, ge);
    flip_idx = -1;
    chk("t3_sync_evt", {gv, ge, s_if.LINK_UP}, 3'b010);
    chk("t3_sync_cnt", s_if.ERR_CNT, 16'd2);
    wait_busy(1'b0, "t3_idle2");
    flip_idx = 81;
    wait_evt(gv, ge);
    flip_idx = -1;
    chk("t3_stop_evt", {gv, ge}, 2'b01);
    chk("t3_stop_cnt", s_if.ERR_CNT, 16'd3);
    wait_evt(gv, ge);
    chk("t3_recover", {gv, ge, s_if.LINK_UP}, 3'b101);

    // Test 4: SCL stuck high mid-frame
    wait_idx(30, "t4_idx");
    hold_scl = 1'b1;
    repeat (1100) @(negedge clk);
    wait_evt(gv, ge);
    chk("t4_tmo_evt", {gv, ge}, 2'b01);
    chk("t4_tmo_cnt_up", {s_if.ERR_CNT, s_if.LINK_UP}, {16'd4, 1'b0});
    wait_busy(1'b0, "t4_idle");
    hold_scl = 1'b0;
    wait_evt(gv, ge);
    chk("t4_recover", {gv, ge, s_if.LINK_UP}, 3'b101);
    chk("t4_pay", s_if.RX_PAYLOAD, P1);

    // Test 5: payload change during TX, busy length
    wait_busy(1'b0, "t5_idle");
    wait_busy(1'b1, "t5_busy");
    busy_cyc = 0;
    while (m_if.TX_BUSY && busy_cyc < 2000) begin
      busy_cyc++;
      if (busy_cyc == 100) m_if.TX_PAYLOAD = P2;
      @(negedge clk);
    end
    chk("t5_busy_len", busy_cyc, 656);
    chk("t5_done", m_if.TX_DONE, 1'b1);
    wait_evt(gv, ge);
    chk("t5_old_evt", {gv, ge}, 2'b10);
    chk("t5_old_pay", s_if.RX_PAYLOAD, P1);
    wait_evt(gv, ge);
    chk("t5_new_evt", {gv, ge}, 2'b10);
    chk("t5_new_pay", s_if.RX_PAYLOAD, P2);
    chk("t5_frame", cap, mk_frame(P2));

    // Test 6: reset mid-frame, then slave briefly switched to master mid-frame
    wait_idx(40, "t6_idx");
    rst = 1'b1;
    #1;
    chk_reset("t6_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vseen = vcnt;
    eseen = ecnt;
    wait_evt(gv, ge);
    chk("t6_after_rst", {gv, ge, s_if.LINK_UP}, 3'b101);
    chk("t6_pay", s_if.RX_PAYLOAD, P2);
    wait_idx(20, "t6_idx2");
    s_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_mode_up_oe", {s_if.LINK_UP, s_if.LINK_OE}, 2'b01);
    wait_busy(1'b0, "t6_idle");
    s_mode = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_back_oe", s_if.LINK_OE, 1'b0);
    chk("t6_no_spurious", {vcnt, ecnt}, {vseen, eseen});
    chk("t6_kept", {s_if.RX_PAYLOAD, s_if.ERR_CNT}, {P2, 16'd0});
    wait_evt(gv, ge);
    chk("t6_next", {gv, ge, s_if.LINK_UP}, 3'b101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
